// File: rtl/juego_pkg.sv
// ----------------------------------------------------------------------------
// juego_pkg
// Shared definitions for the player-control logic:
//   - estado_t        : movement FSM state encoding
//   - DEBOUNCE_CYCLES_DEF / STEP_PERIOD_DEF : default timing constants
//   - ACCEL_STEPS     : consecutive issued steps before the interval halves
//                       (only used when CONTROL_JUGADOR_ACCEL_EN is defined)
//   - es_move()       : true for the two moving states
// ----------------------------------------------------------------------------
package juego_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MOVE_IZQ = 2'd1,
        MOVE_DER = 2'd2,
        LOCK     = 2'd3
    } estado_t;

    localparam int DEBOUNCE_CYCLES_DEF = 250000;
    localparam int STEP_PERIOD_DEF     = 833333;
    localparam int ACCEL_STEPS         = 8;

    function automatic logic es_move(input estado_t s);
        return (s == MOVE_IZQ) || (s == MOVE_DER);
    endfunction

endpackage

// File: rtl/antirrebote.sv
// ----------------------------------------------------------------------------
// antirrebote
// Two-flop synchronizer followed by a debounce counter for one push-button.
// The debounced level only changes after the synchronized level has differed
// from it for DEBOUNCE_CYCLES consecutive cycles.
// Ports:
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset (clears everything to 0)
//   btn_in   in  raw button, asynchronous to clk
//   btn_out  out debounced, synchronized level
// ----------------------------------------------------------------------------
module antirrebote
    import juego_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_in,
    output logic btn_out
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          deb_q,   deb_d;
    logic [CW-1:0] cnt_q,   cnt_d;

    always_comb begin
        sync1_d = btn_in;
        sync2_d = sync1_q;
        deb_d   = deb_q;
        cnt_d   = '0;
        // Any cycle where the synchronized level matches the accepted one
        // restarts the qualification window.
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_MAX) begin
                deb_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            deb_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            deb_q   <= deb_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_out = deb_q;

endmodule

// File: rtl/control_jugador.sv
// ----------------------------------------------------------------------------
// control_jugador
// Turns the left/right push-buttons into registered one-cycle step pulses for
// the player block. Entering a move state issues a step immediately; holding
// the button repeats it every STEP_PERIOD cycles. A step is only emitted if
// the player has room in that direction, otherwise it is dropped. Pressing
// both buttons locks out movement until both are released.
// Optional feature: define CONTROL_JUGADOR_ACCEL_EN to halve the step interval
// after ACCEL_STEPS consecutive issued steps in the same move state.
// Ports:
//   clk        in  system clock
//   reset_n    in  asynchronous active-low reset
//   btn_izq    in  raw left button
//   btn_der    in  raw right button
//   espacioAb  in  room to move left
//   espacioAr  in  room to move right
//   izq        out one-cycle left step pulse
//   der        out one-cycle right step pulse
//   moving     out high while in MOVE_IZQ or MOVE_DER
// ----------------------------------------------------------------------------
module control_jugador
    import juego_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int STEP_PERIOD     = STEP_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn_izq,
    input  logic btn_der,
    input  logic espacioAb,
    input  logic espacioAr,
    output logic izq,
    output logic der,
    output logic moving
);

    localparam int PW = $clog2(STEP_PERIOD + 1);
    localparam logic [PW-1:0] FULL_MAX = PW'(STEP_PERIOD - 1);

    logic    deb_izq, deb_der;
    estado_t state_q, state_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic    izq_q, izq_d;
    logic    der_q, der_d;
    logic    moving_q, moving_d;
    logic    step;
    logic [PW-1:0] limit;

    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_izq (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_in  (btn_izq),
        .btn_out (deb_izq)
    );

    antirrebote #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_der (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_in  (btn_der),
        .btn_out (deb_der)
    );

`ifdef CONTROL_JUGADOR_ACCEL_EN
    localparam int HALF = (STEP_PERIOD / 2 > 0) ? STEP_PERIOD / 2 : 1;
    localparam logic [PW-1:0] HALF_MAX = PW'(HALF - 1);

    logic [3:0] pasos_q, pasos_d;

    assign limit = (pasos_q >= 4'(ACCEL_STEPS)) ? HALF_MAX : FULL_MAX;

    // Counts consecutive issued steps; a dropped step or any state change
    // restarts the run. Saturates once the fast interval is reached.
    always_comb begin
        pasos_d = pasos_q;
        if (state_d != state_q) begin
            pasos_d = (izq_d || der_d) ? 4'd1 : 4'd0;
        end else if (step) begin
            if (izq_d || der_d) begin
                if (pasos_q < 4'(ACCEL_STEPS)) begin
                    pasos_d = pasos_q + 4'd1;
                end
            end else begin
                pasos_d = 4'd0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pasos_q <= 4'd0;
        end else begin
            pasos_q <= pasos_d;
        end
    end
`else
    assign limit = FULL_MAX;
`endif

    // Next-state, period counter and registered-output inputs.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (deb_izq && deb_der)  state_d = LOCK;
                else if (deb_izq)        state_d = MOVE_IZQ;
                else if (deb_der)        state_d = MOVE_DER;
            end
            MOVE_IZQ: begin
                if (!deb_izq)            state_d = IDLE;
                else if (deb_der)        state_d = LOCK;
            end
            MOVE_DER: begin
                if (!deb_der)            state_d = IDLE;
                else if (deb_izq)        state_d = LOCK;
            end
            LOCK: begin
                if (!deb_izq && !deb_der) state_d = IDLE;
            end
            default:                     state_d = IDLE;
        endcase

        step  = 1'b0;
        cnt_d = '0;
        if (state_d != state_q) begin
            // First cycle of a move state always requests a step.
            step = es_move(state_d);
        end else if (es_move(state_q)) begin
            if (cnt_q >= limit) begin
                step = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end

        izq_d    = step && (state_d == MOVE_IZQ) && espacioAb;
        der_d    = step && (state_d == MOVE_DER) && espacioAr;
        moving_d = es_move(state_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            izq_q    <= 1'b0;
            der_q    <= 1'b0;
            moving_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            izq_q    <= izq_d;
            der_q    <= der_d;
            moving_q <= moving_d;
        end
    end

    assign izq    = izq_q;
    assign der    = der_q;
    assign moving = moving_q;

endmodule
